// File: rtl/equiv_sweep_ctrl_if.sv
// Bus between the equivalence sweep controller and its environment:
// start/result handshake plus the shared vector and the two unit outputs.
interface equiv_sweep_ctrl_if #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned N_OUT = 2
);
    logic              start;
    logic [N_IN-1:0]   vec;
    logic [N_OUT-1:0]  y_a;
    logic [N_OUT-1:0]  y_b;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic              fail_valid;
    logic [N_IN-1:0]   fail_vec;

    // Controller side
    modport master (
        input  start, y_a, y_b,
        output vec, busy, done, pass, err_count, fail_valid, fail_vec
    );

    // Environment side: issues start, supplies unit outputs, reads results
    modport slave (
        output start, y_a, y_b,
        input  vec, busy, done, pass, err_count, fail_valid, fail_vec
    );
endinterface

// File: rtl/equiv_sweep_ctrl.sv
// Exhaustive equivalence sweep controller: drives every N_IN-bit vector to
// units A and B, holds each for SETTLE cycles, then compares their outputs.
// Optional macro SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module equiv_sweep_ctrl #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic                clk,
    input  logic                reset,
    equiv_sweep_ctrl_if.master  bus
);
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned ERR_W = N_IN + 1;
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              fv_q, fv_d;
    logic [N_IN-1:0]   fvec_q, fvec_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic [N_OUT-1:0]  y_a_c, y_b_c;
    logic              mismatch_c;
    logic              last_c;

    assign y_a_c      = bus.y_a;
    assign y_b_c      = bus.y_b;
    assign mismatch_c = (y_a_c != y_b_c);

    // State and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Sweep sequencing: settle, compare, advance or finish
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fvec_d  = fvec_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        last_c  = (vec_q == VEC_LAST);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    vec_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fvec_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (mismatch_c) begin
                    err_d = err_q + ERR_W'(1);
                    if (!fv_q) begin
                        fv_d   = 1'b1;
                        fvec_d = vec_q;
                    end
                end
`ifdef SWEEP_STOP_ON_FAIL_EN
                last_c = last_c || mismatch_c;
`endif
                if (last_c) begin
                    state_d = S_DONE;
                    vec_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = S_WAIT;
                    vec_d   = vec_q + N_IN'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.vec        = vec_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_valid = fv_q;
    assign bus.fail_vec   = fvec_q;
endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Bench for equiv_sweep_ctrl (N_IN=3, N_OUT=2, SETTLE=1): unit A is a
// 3-input popcount, unit B is popcount with a per-test fault pattern.
module tb_equiv_sweep_ctrl;
    localparam int N_IN   = 3;
    localparam int N_OUT  = 2;
    localparam int SETTLE = 1;
    localparam int NVEC   = 1 << N_IN;

    logic clk = 1'b0;
    logic reset;
    int   mode;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_en = 1'b0;

    // model state: phase 0=idle 1=sweeping 2=done; k = cycles since start
    int   m_ph = 0;
    int   m_k  = 0;
    int   m_md = 0;

    equiv_sweep_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) dut_if ();

    equiv_sweep_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.master)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] pc(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

    // unit B: 0 correct, 1 wrong at 5, 2 inverted everywhere, 3 wrong at 2
    function automatic logic [1:0] unit_b(input int md, input logic [2:0] v);
        logic [1:0] p;
        p = pc(v);
        case (md)
            1: return (v == 3'd5) ? (p ^ 2'b01) : p;
            2: return ~p;
            3: return (v == 3'd2) ? (p ^ 2'b10) : p;
            default: return p;
        endcase
    endfunction

    function automatic bit mism(input int md, input int v);
        return pc(3'(v)) != unit_b(md, 3'(v));
    endfunction

    // number of vectors the sweep visits for a given fault pattern
    function automatic int limit(input int md);
`ifdef SWEEP_STOP_ON_FAIL_EN
        for (int v = 0; v < NVEC; v++) if (mism(md, v)) return v + 1;
`endif
        return NVEC;
    endfunction

    always_comb begin
        dut_if.y_a = pc(dut_if.vec);
        dut_if.y_b = unit_b(mode, dut_if.vec);
    end

    // reference: track phase and elapsed cycles from the sampled inputs
    always @(posedge clk) begin
        if (reset) begin
            m_ph <= 0;
            m_k  <= 0;
        end else if (m_ph != 1 && dut_if.start) begin
            m_ph <= 1;
            m_k  <= 0;
            m_md <= mode;
        end else if (m_ph == 1) begin
            m_k <= m_k + 1;
            if (m_k + 1 == limit(m_md) * (SETTLE + 1)) m_ph <= 2;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // compare every output against the reference on each falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            int n, e, fv, fvec, ev, eb, ed, ep;
            n = 0; ev = 0; eb = 0; ed = 0;
            if (m_ph == 1) begin
                n  = m_k / (SETTLE + 1);
                ev = n;
                eb = 1;
            end else if (m_ph == 2) begin
                n  = limit(m_md);
                ed = 1;
            end
            e = 0; fv = 0; fvec = 0;
            for (int v = 0; v < n; v++) begin
                if (mism(m_md, v)) begin
                    if (fv == 0) fvec = v;
                    fv = 1;
                    e++;
                end
            end
            ep = (ed == 1 && e == 0) ? 1 : 0;
            chk("vec",        32'(dut_if.vec),        32'(ev));
            chk("busy",       32'(dut_if.busy),       32'(eb));
            chk("done",       32'(dut_if.done),       32'(ed));
            chk("pass",       32'(dut_if.pass),       32'(ep));
            chk("err_count",  32'(dut_if.err_count),  32'(e));
            chk("fail_valid", 32'(dut_if.fail_valid), 32'(fv));
            if (fv == 1) chk("fail_vec", 32'(dut_if.fail_vec), 32'(fvec));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pulse start, optionally re-pulse at busy cycle inj, count busy cycles
    task automatic run_sweep(input int inj, output int bc, output bit ok);
        dut_if.start = 1'b1;
        tick();
        dut_if.start = 1'b0;
        bc = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dut_if.busy) bc++;
            if (dut_if.done) begin
                ok = 1'b1;
                break;
            end
            dut_if.start = (inj != 0 && bc == inj && dut_if.busy);
            tick();
            dut_if.start = 1'b0;
        end
        chk("sweep_timeout", 32'(ok), 32'd1);
    endtask

    int bc;
    bit ok;
    int full_bc;

    initial begin
        reset = 1'b1;
        dut_if.start = 1'b0;
        mode = 0;
        tick();
        tick();
        cmp_en = 1'b1;
        chk("rst_vec",  32'(dut_if.vec), 32'd0);
        chk("rst_busy", 32'(dut_if.busy), 32'd0);
        chk("rst_done", 32'(dut_if.done), 32'd0);
        chk("rst_err",  32'(dut_if.err_count), 32'd0);
        reset = 1'b0;
        tick();

        // both units agree
        mode = 0;
        run_sweep(0, bc, ok);
        chk("t1_busy_cycles", 32'(bc), 32'd16);
        chk("t1_pass", 32'(dut_if.pass), 32'd1);
        chk("t1_err",  32'(dut_if.err_count), 32'd0);
        chk("t1_fv",   32'(dut_if.fail_valid), 32'd0);

        // single fault at vector 5, restarted from DONE
        mode = 1;
        run_sweep(0, bc, ok);
        chk("t2_err",  32'(dut_if.err_count), 32'd1);
        chk("t2_fv",   32'(dut_if.fail_valid), 32'd1);
        chk("t2_fvec", 32'(dut_if.fail_vec), 32'd5);
        chk("t2_pass", 32'(dut_if.pass), 32'd0);
        tick();

        // B inverted everywhere
        mode = 2;
        run_sweep(0, bc, ok);
`ifdef SWEEP_STOP_ON_FAIL_EN
        chk("t3_err", 32'(dut_if.err_count), 32'd1);
        chk("t3_busy_cycles", 32'(bc), 32'd2);
`else
        chk("t3_err", 32'(dut_if.err_count), 32'd8);
        chk("t3_busy_cycles", 32'(bc), 32'd16);
`endif
        chk("t3_fvec", 32'(dut_if.fail_vec), 32'd0);
        chk("t3_pass", 32'(dut_if.pass), 32'd0);

        // reset mid-sweep at vec=4, then a clean sweep
        mode = 0;
        dut_if.start = 1'b1;
        tick();
        dut_if.start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (dut_if.vec == 3'd4) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("t4_reach_vec4", 32'(ok), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_vec",  32'(dut_if.vec), 32'd0);
        chk("t4_busy", 32'(dut_if.busy), 32'd0);
        chk("t4_done", 32'(dut_if.done), 32'd0);
        tick();
        run_sweep(0, bc, ok);
        chk("t4_busy_cycles", 32'(bc), 32'd16);
        chk("t4_pass", 32'(dut_if.pass), 32'd1);

        // start while busy is ignored
        mode = 3;
        run_sweep(5, bc, ok);
        full_bc = bc;
`ifdef SWEEP_STOP_ON_FAIL_EN
        chk("t5_busy_cycles", 32'(full_bc), 32'd6);
`else
        chk("t5_busy_cycles", 32'(full_bc), 32'd16);
`endif
        chk("t5_err",  32'(dut_if.err_count), 32'd1);
        chk("t5_fvec", 32'(dut_if.fail_vec), 32'd2);

        // start while done clears results and re-sweeps
        mode = 0;
        dut_if.start = 1'b1;
        tick();
        dut_if.start = 1'b0;
        chk("t5_restart_done", 32'(dut_if.done), 32'd0);
        chk("t5_restart_err",  32'(dut_if.err_count), 32'd0);
        chk("t5_restart_fv",   32'(dut_if.fail_valid), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (dut_if.done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("t5_resweep_done", 32'(ok), 32'd1);
        chk("t5_resweep_pass", 32'(dut_if.pass), 32'd1);

        // stop-on-fail behaviour: first mismatch at vector 2
        mode = 3;
        run_sweep(0, bc, ok);
`ifdef SWEEP_STOP_ON_FAIL_EN
        chk("t6_busy_cycles", 32'(bc), 32'd6);
`else
        chk("t6_busy_cycles", 32'(bc), 32'd16);
`endif
        chk("t6_err",  32'(dut_if.err_count), 32'd1);
        chk("t6_fvec", 32'(dut_if.fail_vec), 32'd2);
        chk("t6_pass", 32'(dut_if.pass), 32'd0);

        // reset and start together: reset wins
        reset = 1'b1;
        dut_if.start = 1'b1;
        tick();
        reset = 1'b0;
        dut_if.start = 1'b0;
        chk("t7_busy", 32'(dut_if.busy), 32'd0);
        chk("t7_done", 32'(dut_if.done), 32'd0);
        tick();
        chk("t7_busy_after", 32'(dut_if.busy), 32'd0);
        tick();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
